irq_request_reg_sync: RTL and testbench

Parametrised, clocked successor to the 8259A interrupt request register. It synchronises NUM_IRQ asynchronous request lines and latches them in edge-triggered or level-triggered mode (the LTIM mode). It applies the IMR mask, freezes its contents during the INTA sequence, and clears one serviced bit on command from the priority resolver. It sits between the IR pins and the priority resolver/control logic; it drives the resolver input, the INT request, and the IRR read-back path to the data bus buffer.

---
 rtl/irq_request_reg_sync.sv | 80 ++++++++
 tb/tb_irq_request_reg_sync.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/irq_request_reg_sync.sv
// Interrupt request register: synchronises IR lines and latches them in edge or
// level mode, with masking, freeze during INTA, and serviced-bit clear.
module irq_request_reg_sync #(
  parameter int NUM_IRQ = 8,
  parameter int IDX_W   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               level_mode,
  input  logic               init,
  input  logic [NUM_IRQ-1:0] imr_mask,
  input  logic               freeze,
  input  logic               clr_valid,
  input  logic [IDX_W-1:0]   clr_index,
  input  logic               read_irr,
  output logic [NUM_IRQ-1:0] irr_q,
  output logic [NUM_IRQ-1:0] irr_masked,
  output logic               int_req,
  output logic [NUM_IRQ-1:0] data_out
);

  logic [NUM_IRQ-1:0] sync1_q, sync1_d;
  logic [NUM_IRQ-1:0] sync2_q, sync2_d;
  logic [NUM_IRQ-1:0] prev_q, prev_d;
  logic [NUM_IRQ-1:0] irr_d;
  logic               int_req_q, int_req_d;

  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] clr_vec;
  logic [NUM_IRQ-1:0] base;
  logic [NUM_IRQ-1:0] keep;

  assign irr_masked = irr_q & ~imr_mask;
  assign int_req    = int_req_q;
  assign data_out   = read_irr ? irr_q : '0;

  always_comb begin
    sync1_d   = irq_in;
    sync2_d   = sync1_q;
    prev_d    = sync2_q;
    rise      = sync2_q & ~prev_q;
    clr_vec   = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      clr_vec[i] = clr_valid && (clr_index == IDX_W'(i));
    end
    if (freeze) begin
      base = irr_q;
    end else if (level_mode) begin
      base = sync2_q;
    end else begin
      base = sync2_q & (irr_q | rise);
    end
    // a fresh edge-mode request beats a same-cycle clear
    keep      = (freeze || level_mode) ? '0 : rise;
    irr_d     = base & ~(clr_vec & ~keep);
    if (init) begin
      irr_d  = '0;
      prev_d = '1;
    end
    int_req_d = |irr_masked;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '1;
      irr_q     <= '0;
      int_req_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      prev_q    <= prev_d;
      irr_q     <= irr_d;
      int_req_q <= int_req_d;
    end
  end

endmodule

// File: tb/tb_irq_request_reg_sync.sv
// Directed bench for irq_request_reg_sync: 8-channel and 16-channel instances
// driven through hand-computed sequences.
module tb_irq_request_reg_sync;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic level_mode = 1'b0;
  logic init = 1'b0;
  logic freeze = 1'b0;

  logic [7:0] irq8 = '0, mask8 = '0;
  logic       clr8 = 1'b0, rd8 = 1'b0;
  logic [2:0] idx8 = '0;
  logic [7:0] irr8, msk8o, dout8;
  logic       int8;

  logic [15:0] irq16 = '0, mask16 = '0;
  logic        clr16 = 1'b0, rd16 = 1'b0;
  logic [3:0]  idx16 = '0;
  logic [15:0] irr16, msk16o, dout16;
  logic        int16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  irq_request_reg_sync #(.NUM_IRQ(8), .IDX_W(3)) u8 (
    .clk(clk), .rst_n(rst_n), .irq_in(irq8),
    .level_mode(level_mode), .init(init),
    .imr_mask(mask8), .freeze(freeze),
    .clr_valid(clr8), .clr_index(idx8),
    .read_irr(rd8), .irr_q(irr8),
    .irr_masked(msk8o), .int_req(int8),
    .data_out(dout8)
  );

  irq_request_reg_sync #(.NUM_IRQ(16), .IDX_W(4)) u16 (
    .clk(clk), .rst_n(rst_n), .irq_in(irq16),
    .level_mode(level_mode), .init(init),
    .imr_mask(mask16), .freeze(freeze),
    .clr_valid(clr16), .clr_index(idx16),
    .read_irr(rd16), .irr_q(irr16),
    .irr_masked(msk16o), .int_req(int16),
    .data_out(dout16)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #1;
    chk("rst_irr8", 64'(irr8), 64'h0);
    chk("rst_int8", 64'(int8), 64'h0);
    chk("rst_irr16", 64'(irr16), 64'h0);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    chk("idle_irr8", 64'(irr8), 64'h0);

    // 1: edge latch, latency, clear
    irq8 = 8'h04;
    tick(1);
    chk("t1_k", 64'(irr8), 64'h0);
    tick(1);
    chk("t1_k1", 64'(irr8), 64'h0);
    tick(1);
    chk("t1_k2_irr", 64'(irr8), 64'h04);
    chk("t1_k2_int", 64'(int8), 64'h0);
    tick(1);
    chk("t1_k3_int", 64'(int8), 64'h1);
    clr8 = 1'b1;
    idx8 = 3'd2;
    tick(1);
    clr8 = 1'b0;
    chk("t1_clr_irr", 64'(irr8), 64'h00);
    tick(1);
    chk("t1_clr_int", 64'(int8), 64'h0);
    irq8 = 8'h00;
    tick(3);

    // 2: init with line held high
    irq8 = 8'h20;
    tick(3);
    chk("t2_pre", 64'(irr8), 64'h20);
    init = 1'b1;
    tick(1);
    init = 1'b0;
    chk("t2_init", 64'(irr8), 64'h00);
    tick(3);
    chk("t2_held", 64'(irr8), 64'h00);
    irq8 = 8'h00;
    tick(3);
    irq8 = 8'h20;
    tick(2);
    chk("t2_rise_k1", 64'(irr8), 64'h00);
    tick(1);
    chk("t2_rise_k2", 64'(irr8), 64'h20);
    tick(1);
    chk("t2_int", 64'(int8), 64'h1);
    irq8 = 8'h00;
    tick(4);
    chk("t2_drop", 64'(irr8), 64'h00);

    // 3: level mode with mask
    level_mode = 1'b1;
    mask8 = 8'h80;
    irq8 = 8'h81;
    rd8 = 1'b1;
    tick(3);
    chk("t3_irr", 64'(irr8), 64'h81);
    chk("t3_msk", 64'(msk8o), 64'h01);
    chk("t3_dout", 64'(dout8), 64'h81);
    tick(1);
    chk("t3_int", 64'(int8), 64'h1);
    irq8 = 8'h80;
    tick(3);
    chk("t3_drop_irr", 64'(irr8), 64'h80);
    chk("t3_drop_msk", 64'(msk8o), 64'h00);
    tick(1);
    chk("t3_drop_int", 64'(int8), 64'h0);
    mask8 = 8'h00;
    #1;
    chk("t3_unmask_msk", 64'(msk8o), 64'h80);
    chk("t3_unmask_irr", 64'(irr8), 64'h80);
    rd8 = 1'b0;
    #1;
    chk("t3_dout_off", 64'(dout8), 64'h00);
    irq8 = 8'h00;
    level_mode = 1'b0;
    tick(4);
    chk("t3_end", 64'(irr8), 64'h00);

    // 4: freeze
    irq8 = 8'h10;
    tick(3);
    chk("t4_pre", 64'(irr8), 64'h10);
    freeze = 1'b1;
    irq8 = 8'h00;
    tick(4);
    chk("t4_hold", 64'(irr8), 64'h10);
    clr8 = 1'b1;
    idx8 = 3'd4;
    tick(1);
    clr8 = 1'b0;
    chk("t4_clr", 64'(irr8), 64'h00);
    freeze = 1'b0;
    tick(2);

    // 5: same-cycle rise and clear
    irq8 = 8'h08;
    tick(2);
    clr8 = 1'b1;
    idx8 = 3'd3;
    tick(1);
    clr8 = 1'b0;
    chk("t5_edge_win", 64'(irr8), 64'h08);
    irq8 = 8'h00;
    tick(4);
    level_mode = 1'b1;
    irq8 = 8'h08;
    tick(3);
    chk("t5_lvl_pre", 64'(irr8), 64'h08);
    clr8 = 1'b1;
    tick(1);
    clr8 = 1'b0;
    chk("t5_lvl_clr", 64'(irr8), 64'h00);
    tick(1);
    chk("t5_lvl_resample", 64'(irr8), 64'h08);
    irq8 = 8'h00;
    level_mode = 1'b0;
    tick(4);

    // 6: 16-channel instance, then async reset
    irq16 = 16'h8000;
    tick(3);
    chk("t6_irr16", 64'(irr16), 64'h8000);
    rd16 = 1'b1;
    #1;
    chk("t6_dout16_on", 64'(dout16), 64'h8000);
    rd16 = 1'b0;
    #1;
    chk("t6_dout16_off", 64'(dout16), 64'h0000);
    clr16 = 1'b1;
    idx16 = 4'd15;
    tick(1);
    clr16 = 1'b0;
    chk("t6_clr15", 64'(irr16), 64'h0000);
    irq8 = 8'h04;
    rd8 = 1'b1;
    tick(4);
    chk("t6_pre_irr8", 64'(irr8), 64'h04);
    chk("t6_pre_int8", 64'(int8), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_irr8", 64'(irr8), 64'h00);
    chk("t6_rst_int8", 64'(int8), 64'h0);
    chk("t6_rst_msk8", 64'(msk8o), 64'h00);
    chk("t6_rst_dout8", 64'(dout8), 64'h00);
    chk("t6_rst_irr16", 64'(irr16), 64'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
